// File: rtl/msf_frame_sequencer.sv
// msf_frame_sequencer: tracks MSF second index, captures A-bit time fields,
// checks B-bit odd parity and end-of-minute marker, commits on the next minute marker.
module msf_frame_sequencer #(
  parameter int LAST_SECOND  = 59,
  parameter bit CHECK_MARKER = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bits_valid_i,
  input  logic       bits_is_second_00_i,
  input  logic [1:0] bits_data_i,
  output logic       synced_o,
  output logic [5:0] second_o,
  output logic       time_valid_o,
  output logic       frame_err_o,
  output logic [7:0] year_o,
  output logic [4:0] month_o,
  output logic [5:0] day_o,
  output logic [2:0] dow_o,
  output logic [5:0] hour_o,
  output logic [6:0] minute_o
);
  typedef enum logic {HUNT, RUN} state_t;
  state_t      state_q, state_d;
  logic [5:0]  second_q, second_d;
  logic [34:0] cap_q, cap_d;
  logic [34:0] time_q, time_d;
  logic [3:0]  par_q, par_d;
  logic        marker_bad_q, marker_bad_d;
  logic        time_valid_q, time_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [5:0]  n;
  logic        a, b, good, in_run;
  assign a      = bits_data_i[1];
  assign b      = bits_data_i[0];
  assign in_run = state_q == RUN;
  assign n      = second_q + 6'd1;
  assign good   = second_q == 6'(LAST_SECOND) && &par_q && (!CHECK_MARKER || !marker_bad_q);
  always_comb begin
    state_d      = state_q;
    second_d     = second_q;
    cap_d        = cap_q;
    time_d       = time_q;
    par_d        = par_q;
    marker_bad_d = marker_bad_q;
    time_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (bits_valid_i && bits_is_second_00_i) begin
      time_valid_d = in_run && good;
      frame_err_d  = in_run && !good;
      time_d       = (in_run && good) ? cap_q : time_q;
      state_d      = RUN;
      second_d     = '0;
      cap_d        = '0;
      par_d        = '0;
      marker_bad_d = 1'b0;
    end else if (bits_valid_i && in_run) begin
      if (second_q == 6'(LAST_SECOND)) begin
        frame_err_d = 1'b1;
        state_d     = HUNT;
        second_d    = '0;
      end else begin
        second_d     = n;
        cap_d        = (n >= 6'd17 && n <= 6'd51) ? {cap_q[33:0], a} : cap_q;
        par_d[0]     = par_q[0] ^ (a && n >= 6'd17 && n <= 6'd24) ^ (b && n == 6'd54);
        par_d[1]     = par_q[1] ^ (a && n >= 6'd25 && n <= 6'd35) ^ (b && n == 6'd55);
        par_d[2]     = par_q[2] ^ (a && n >= 6'd36 && n <= 6'd38) ^ (b && n == 6'd56);
        par_d[3]     = par_q[3] ^ (a && n >= 6'd39 && n <= 6'd51) ^ (b && n == 6'd57);
        // marker pattern 0,1,1,1,1,1,1,0 over seconds 52..59
        marker_bad_d = marker_bad_q | (n >= 6'd52 && n <= 6'd59 && a != (n >= 6'd53 && n <= 6'd58));
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= HUNT;
      second_q     <= '0;
      cap_q        <= '0;
      time_q       <= '0;
      par_q        <= '0;
      marker_bad_q <= 1'b0;
      time_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      second_q     <= second_d;
      cap_q        <= cap_d;
      time_q       <= time_d;
      par_q        <= par_d;
      marker_bad_q <= marker_bad_d;
      time_valid_q <= time_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end
  assign synced_o     = in_run;
  assign second_o     = second_q;
  assign time_valid_o = time_valid_q;
  assign frame_err_o  = frame_err_q;
  assign year_o       = time_q[34:27];
  assign month_o      = time_q[26:22];
  assign day_o        = time_q[21:16];
  assign dow_o        = time_q[15:13];
  assign hour_o       = time_q[12:7];
  assign minute_o     = time_q[6:0];
endmodule

// File: tb/tb_msf_frame_sequencer.sv
// tb_msf_frame_sequencer: randomized MSF frames checked against a per-second bit-array model.
module tb_msf_frame_sequencer;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       bits_valid_i = 1'b0;
  logic       bits_is_second_00_i = 1'b0;
  logic [1:0] bits_data_i = 2'b00;
  logic       synced_o, time_valid_o, frame_err_o;
  logic [5:0] second_o, day_o, hour_o;
  logic [7:0] year_o;
  logic [4:0] month_o;
  logic [2:0] dow_o;
  logic [6:0] minute_o;
  int checks = 0, failures = 0;
  msf_frame_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bits_valid_i(bits_valid_i),
    .bits_is_second_00_i(bits_is_second_00_i), .bits_data_i(bits_data_i),
    .synced_o(synced_o), .second_o(second_o), .time_valid_o(time_valid_o),
    .frame_err_o(frame_err_o), .year_o(year_o), .month_o(month_o), .day_o(day_o),
    .dow_o(dow_o), .hour_o(hour_o), .minute_o(minute_o)
  );
  always #5 clk_i = ~clk_i;
  // reference model: bits received this minute, indexed by second
  logic m_sync, exp_tv, exp_fe;
  int   m_sec;
  logic m_a[60], m_b[60];
  logic [7:0] m_year, m_month, m_day, m_dow, m_hour, m_min;
  logic fa[62], fb[62];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] field(input int lo, input int hi);
    logic [7:0] v = '0;
    for (int s = lo; s <= hi; s++) v = {v[6:0], m_a[s]};
    return v;
  endfunction
  function automatic logic group_xor(input int lo, input int hi, input int bs);
    logic x = m_b[bs];
    for (int s = lo; s <= hi; s++) x ^= m_a[s];
    return x;
  endfunction
  function automatic logic frame_ok();
    if (m_sec != 59) return 1'b0;
    if (!(group_xor(17, 24, 54) && group_xor(25, 35, 55) && group_xor(36, 38, 56) && group_xor(39, 51, 57))) return 1'b0;
    for (int s = 52; s <= 59; s++) if (m_a[s] != (s >= 53 && s <= 58)) return 1'b0;
    return 1'b1;
  endfunction
  task automatic model_reset();
    m_sync = 0; m_sec = 0; exp_tv = 0; exp_fe = 0;
    m_year = 0; m_month = 0; m_day = 0; m_dow = 0; m_hour = 0; m_min = 0;
    for (int s = 0; s < 60; s++) begin m_a[s] = 0; m_b[s] = 0; end
  endtask
  task automatic model_strobe(input logic m, input logic a, input logic b);
    exp_tv = 0; exp_fe = 0;
    if (m) begin
      if (m_sync && frame_ok()) begin
        exp_tv = 1;
        m_year = field(17, 24); m_month = field(25, 29); m_day = field(30, 35);
        m_dow = field(36, 38); m_hour = field(39, 44); m_min = field(45, 51);
      end else if (m_sync) exp_fe = 1;
      m_sync = 1; m_sec = 0;
      for (int s = 0; s < 60; s++) begin m_a[s] = 0; m_b[s] = 0; end
    end else if (m_sync) begin
      if (m_sec == 59) begin exp_fe = 1; m_sync = 0; m_sec = 0; end
      else begin m_sec++; m_a[m_sec] = a; m_b[m_sec] = b; end
    end
  endtask
  task automatic cmp_all();
    check("synced", synced_o, m_sync);
    check("second", second_o, m_sec);
    check("time_valid", time_valid_o, exp_tv);
    check("frame_err", frame_err_o, exp_fe);
    check("year", year_o, m_year);
    check("month", month_o, m_month);
    check("day", day_o, m_day);
    check("dow", dow_o, m_dow);
    check("hour", hour_o, m_hour);
    check("minute", minute_o, m_min);
  endtask
  task automatic send(input logic m, input logic a, input logic b);
    @(negedge clk_i);
    bits_valid_i = 1; bits_is_second_00_i = m; bits_data_i = {a, b};
    @(negedge clk_i);
    bits_valid_i = 0; bits_is_second_00_i = $urandom_range(0, 1); bits_data_i = 2'($urandom);
    model_strobe(m, a, b);
    cmp_all();
    repeat ($urandom_range(0, 1)) begin
      @(negedge clk_i);
      exp_tv = 0; exp_fe = 0;
      cmp_all();
    end
  endtask
  // kind: 0 good, 1 flip a parity B bit, 2 flip a marker A bit, 3 flip a data A bit
  task automatic build(input logic [34:0] f, input int kind);
    logic x;
    for (int s = 0; s < 62; s++) begin fa[s] = 1'($urandom); fb[s] = 1'($urandom); end
    for (int i = 0; i < 35; i++) fa[17 + i] = f[34 - i];
    for (int s = 52; s <= 59; s++) fa[s] = (s >= 53 && s <= 58);
    x = 0; for (int s = 17; s <= 24; s++) x ^= fa[s]; fb[54] = ~x;
    x = 0; for (int s = 25; s <= 35; s++) x ^= fa[s]; fb[55] = ~x;
    x = 0; for (int s = 36; s <= 38; s++) x ^= fa[s]; fb[56] = ~x;
    x = 0; for (int s = 39; s <= 51; s++) x ^= fa[s]; fb[57] = ~x;
    if (kind == 1) begin int k = 54 + $urandom_range(0, 3); fb[k] = ~fb[k]; end
    if (kind == 2) begin int k = 52 + $urandom_range(0, 7); fa[k] = ~fa[k]; end
    if (kind == 3) begin int k = 17 + $urandom_range(0, 34); fa[k] = ~fa[k]; end
  endtask
  task automatic send_body(input int len);
    for (int s = 1; s <= len; s++) send(0, fa[s], fb[s]);
  endtask
  localparam logic [34:0] DIR = {8'h23, 5'h03, 6'h15, 3'd3, 6'h12, 7'h34};
  initial begin
    model_reset();
    #3;
    cmp_all();
    @(negedge clk_i) rst_ni = 1;
    build(DIR, 0);
    send_body(59);
    send(0, 1, 1);
    send(1, 0, 0);
    build(DIR, 0);
    send_body(59);
    send(1, 0, 0);
    check("dir_year", year_o, 8'h23);
    check("dir_month", month_o, 5'h03);
    check("dir_day", day_o, 6'h15);
    check("dir_dow", dow_o, 3'd3);
    check("dir_hour", hour_o, 6'h12);
    check("dir_minute", minute_o, 7'h34);
    build(DIR, 0);
    fb[57] = ~fb[57];
    send_body(59);
    send(1, 0, 0);
    check("b57_err", frame_err_o | (exp_fe & 1'b0), 1'b1);
    send_body(61);
    check("long_unsync", synced_o, 1'b0);
    send(1, 0, 0);
    build(DIR, 0);
    send_body(40);
    send(1, 0, 0);
    check("short_second", second_o, 6'd0);
    build(35'($urandom) ^ (35'($urandom) << 3), 0);
    send_body(59);
    send(1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      int kind = $urandom_range(0, 5);
      build({$urandom, 3'($urandom)}, kind > 3 ? 0 : kind);
      send_body(kind == 4 ? $urandom_range(20, 58) : kind == 5 ? $urandom_range(60, 61) : 59);
      send(1, 0, 0);
    end
    build(DIR, 0);
    send_body(30);
    #2 rst_ni = 0;
    #1;
    model_reset();
    cmp_all();
    @(negedge clk_i) rst_ni = 1;
    send(1, 0, 0);
    build(DIR, 0);
    send_body(59);
    send(1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/msf_frame_sequencer.md
Name: msf_frame_sequencer

Overview:
Sequences the per-second bit pairs produced by the MSF `decoder` block across a 60-second minute frame. It tracks the second index and captures the A-bit time/date fields. It checks the four B-bit odd-parity groups and the A-bit end-of-minute marker. On the next second-00 marker it commits a validated timestamp. It sits between `decoder` and the clock/display logic.

Parameters:
LAST_SECOND, 59, highest legal second index in a frame; any further non-00 second is a frame error.
CHECK_MARKER, 1, when 1, A bits at seconds 52..59 must equal 0,1,1,1,1,1,1,0 for a frame to commit.

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
bits_valid_i  input  1  one-cycle strobe from `decoder`: a second's bits are available
bits_is_second_00_i  input  1  qualifies bits_valid_i: this strobe is the minute marker
bits_data_i  input  2  [1]=A bit, [0]=B bit for the current second
synced_o  output  1  1 while in RUN state
second_o  output  6  current second index (0..LAST_SECOND), valid when synced_o=1
time_valid_o  output  1  one-cycle pulse: time outputs were updated this cycle
frame_err_o  output  1  one-cycle pulse: frame discarded (parity, marker or length error)
year_o  output  8  BCD year (A17..A24)
month_o  output  5  BCD month (A25..A29)
day_o  output  6  BCD day of month (A30..A35)
dow_o  output  3  day of week (A36..A38)
hour_o  output  6  BCD hour (A39..A44)
minute_o  output  7  BCD minute (A45..A51)

Behaviour:
- Reset (async assert, sync-deassert-safe):
  - state=HUNT; second counter=0; shift register and parity accumulators=0.
  - synced_o=0, second_o=0, time_valid_o=0, frame_err_o=0.
  - All time outputs = 0.
- All actions occur only on a cycle with bits_valid_i=1. Otherwise all state holds and the pulse outputs are 0.
- HUNT state:
  - Non-00 strobes are ignored.
  - A second_00 strobe → RUN, second=0, accumulators cleared.
  - No commit and no frame_err_o.
- RUN state, non-00 strobe:
  - If second==LAST_SECOND: frame_err_o=1, → HUNT, second=0.
  - Else second increments by 1 and the new index N is used for capture:
    - N in 17..51: A shifted into a 35-bit capture register, MSB first.
    - Group parity accumulators XOR in A: P1 over 17..24, P2 over 25..35, P3 over 36..38, P4 over 39..51.
    - N=54,55,56,57: B XORed into P1, P2, P3, P4 respectively.
    - N in 52..59: A compared with marker pattern, any mismatch sets a sticky marker_bad flag.
- RUN state, second_00 strobe:
  - Frame is good iff second==LAST_SECOND, P1..P4 all equal 1 (odd parity), and (CHECK_MARKER=0 or marker_bad=0).
  - Good frame:
    - Time outputs are loaded from the capture register.
    - time_valid_o=1 in the cycle after the strobe (registered, latency 1).
  - Bad frame: frame_err_o=1 (latency 1), time outputs hold previous values.
  - Either way: state stays RUN, second=0, capture, parity and marker_bad cleared.
- second_00 before second reaches LAST_SECOND (short frame) is a bad frame, and the block resyncs to that marker.
- time_valid_o and frame_err_o are never both 1 in the same cycle.
- Asserting reset mid-frame discards all partial state immediately; outputs return to reset values.

Test Plan:
- Reset then 60 good strobes with no preceding marker → synced_o stays 0, no pulses, time outputs stay 0.
- Marker, then a frame encoding year=0x23, month=0x03, day=0x15, dow=3, hour=0x12, minute=0x34 with correct odd parity and marker bits, then marker → time_valid_o pulses once, one cycle after the strobe, with those exact values; second_o=0, synced_o=1.
- Same frame with B at second 57 inverted → frame_err_o pulses, time_valid_o=0, outputs keep the prior values, synced_o remains 1.
- Marker, then 61 non-00 strobes → frame_err_o on the 60th non-00 strobe (second already 59), synced_o=0; next marker resyncs.
- Marker at second 40 → frame_err_o=1, second_o=0, next full good frame commits normally.
- Reset asserted at second 30 of a good frame → all outputs 0 immediately; after release, the following marker only resyncs (no time_valid_o).
